// File: rtl/cpu_trace_pkg.sv
// Shared types and sizing helpers for the CPU trace capture unit.
// Optional timestamp field controlled by TRACE_TIMESTAMP_EN.
package cpu_trace_pkg;

  localparam int TS_W       = 16;
  localparam int CPU_DATA_W = 19;

`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  function automatic int entry_width(input int data_w);
    return 3 * data_w + TS_EN * TS_W;
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int ENTRY_W = entry_width(CPU_DATA_W);

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]       ts;
`endif
    logic [CPU_DATA_W-1:0] pc;
    logic [CPU_DATA_W-1:0] instr;
    logic [CPU_DATA_W-1:0] result;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port,
// registered read data (1-cycle latency, holds when i_re is low).
module trace_ram #(
  parameter int WIDTH = 57,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trigger-qualified circular trace capture of retired instructions with valid/ready drain.
// Define TRACE_TIMESTAMP_EN to store a free-running 16-bit cycle stamp per entry (o_rd_ts).
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W    = 19,
  parameter int OPC_W     = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_arm,
  input  logic                    i_clear,
  input  logic [OPC_W-1:0]        i_trig_opcode,
  input  logic                    i_cap_valid,
  input  logic [OPC_W-1:0]        i_cap_opcode,
  input  logic [DATA_W-1:0]       i_cap_pc,
  input  logic [DATA_W-1:0]       i_cap_instr,
  input  logic [DATA_W-1:0]       i_cap_result,
  input  logic                    i_rd_ready,
  output logic                    o_rd_valid,
  output logic [DATA_W-1:0]       o_rd_pc,
  output logic [DATA_W-1:0]       o_rd_instr,
  output logic [DATA_W-1:0]       o_rd_result,
`ifdef TRACE_TIMESTAMP_EN
  output logic [TS_W-1:0]         o_rd_ts,
`endif
  output logic                    o_rd_last,
  output logic                    o_armed,
  output logic                    o_triggered,
  output logic                    o_done,
  output logic [$clog2(DEPTH):0]  o_fill_count
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int ENT_W  = entry_width(DATA_W);
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] POST_INIT = FILL_W'(POST_TRIG);

  if (POST_TRIG < 0 || POST_TRIG >= DEPTH) begin : g_bad_post_trig
    $error("cpu_trace_buffer: POST_TRIG must be in [0, DEPTH)");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cpu_trace_buffer: DEPTH must be a power of two >= 4");
  end

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] result;
  } entry_t;

  trace_state_e      r_state;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] r_post;
  logic [FILL_W-1:0] r_pend;
  logic              r_rd_valid;

  entry_t            w_wr_entry;
  entry_t            w_rd_entry;
  logic [ENT_W-1:0]  w_rd_data;
  logic              w_we;
  logic              w_match;
  logic              w_xfer;
  logic              w_load;
  logic [PTR_W-1:0]  w_wptr_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PTR_W-1:0]  w_rptr_start;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   r_ts;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_ts <= '0;
    else         r_ts <= r_ts + 1'b1;
  end

  assign w_wr_entry.ts = r_ts;
  assign o_rd_ts       = r_rd_valid ? w_rd_entry.ts : '0;
`endif

  assign w_wr_entry.pc     = i_cap_pc;
  assign w_wr_entry.instr  = i_cap_instr;
  assign w_wr_entry.result = i_cap_result;

  assign w_we       = i_cap_valid && !i_clear && !i_reset && (r_state == ARMED || r_state == POST);
  assign w_match    = (i_cap_opcode == i_trig_opcode);
  assign w_wptr_nxt = r_wptr + 1'b1;
  assign w_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;
  // Once the buffer has wrapped, the oldest surviving entry sits at the next write slot.
  assign w_rptr_start = (w_fill_nxt == FULL) ? w_wptr_nxt : '0;

  // Prefetch: refill the output register whenever it is empty or being consumed.
  assign w_xfer = r_rd_valid && i_rd_ready;
  assign w_load = (r_state == DONE) && (r_pend != '0) && (!r_rd_valid || i_rd_ready);

  trace_ram #(.WIDTH(ENT_W), .DEPTH(DEPTH), .AW(PTR_W)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wr_entry),
    .i_re    (w_load),
    .i_raddr (r_rptr),
    .o_rdata (w_rd_data)
  );

  assign w_rd_entry = entry_t'(w_rd_data);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_post     <= '0;
      r_pend     <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_clear) begin
      r_state    <= IDLE;
      r_fill     <= '0;
      r_post     <= '0;
      r_pend     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_arm) begin
            r_state <= ARMED;
            r_wptr  <= '0;
            r_fill  <= '0;
          end
        end
        ARMED: begin
          if (i_cap_valid) begin
            r_wptr <= w_wptr_nxt;
            r_fill <= w_fill_nxt;
            if (w_match) begin
              if (POST_TRIG == 0) begin
                r_state <= DONE;
                r_pend  <= w_fill_nxt;
                r_rptr  <= w_rptr_start;
              end else begin
                r_state <= POST;
                r_post  <= POST_INIT;
              end
            end
          end
        end
        POST: begin
          if (i_cap_valid) begin
            r_wptr <= w_wptr_nxt;
            r_fill <= w_fill_nxt;
            r_post <= r_post - 1'b1;
            if (r_post == FILL_W'(1)) begin
              r_state <= DONE;
              r_pend  <= w_fill_nxt;
              r_rptr  <= w_rptr_start;
            end
          end
        end
        DONE: begin
          if (i_arm) begin
            r_state    <= ARMED;
            r_wptr     <= '0;
            r_fill     <= '0;
            r_pend     <= '0;
            r_rd_valid <= 1'b0;
          end else begin
            if (w_load) begin
              r_rptr     <= r_rptr + 1'b1;
              r_pend     <= r_pend - 1'b1;
              r_rd_valid <= 1'b1;
            end else if (w_xfer) begin
              r_rd_valid <= 1'b0;
            end
            if (w_xfer) begin
              r_fill <= r_fill - 1'b1;
              if (r_fill == FILL_W'(1)) r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_pc      = r_rd_valid ? w_rd_entry.pc : '0;
  assign o_rd_instr   = r_rd_valid ? w_rd_entry.instr : '0;
  assign o_rd_result  = r_rd_valid ? w_rd_entry.result : '0;
  assign o_rd_last    = r_rd_valid && (r_fill == FILL_W'(1));
  assign o_armed      = (r_state == ARMED) || (r_state == POST);
  assign o_triggered  = (r_state == POST) || (r_state == DONE);
  assign o_done       = (r_state == DONE);
  assign o_fill_count = r_fill;

endmodule
